// File: rtl/axi_burst_mem.sv
// AXI burst memory: independent write (AW/W/B) and read (AR/R) channels sharing one byte-enable RAM.
// Optional feature macro AXI_MEM_SLVERR_EN: out-of-range word indices get SLVERR instead of wrapping modulo DEPTH.
module axi_burst_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                  ACLK,
  input  logic                  APRESETn,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  input  logic [ADDR_W-1:0]     AW_ADDR,
  input  logic [7:0]            AW_LEN,
  input  logic [1:0]            AW_BURST,
  input  logic                  W_VALID,
  output logic                  W_READY,
  input  logic [DATA_W-1:0]     W_DATA,
  input  logic [DATA_W/8-1:0]   W_STRB,
  input  logic                  W_LAST,
  output logic                  B_VALID,
  input  logic                  B_READY,
  output logic [1:0]            B_RESP,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  input  logic [ADDR_W-1:0]     AR_ADDR,
  input  logic [7:0]            AR_LEN,
  input  logic [1:0]            AR_BURST,
  output logic                  R_VALID,
  input  logic                  R_READY,
  output logic [DATA_W-1:0]     R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_LAST
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_MEM_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_RESP} wstate_t;
  typedef enum logic       {RS_IDLE, RS_DATA}          rstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    word_of = a >> OFF_W;
  endfunction

  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
    mem_idx = IDX_W'(word_of(a) % ADDR_W'(DEPTH));
  endfunction

  function automatic logic beyond(input logic [ADDR_W-1:0] a);
    beyond = SLVERR_EN && (word_of(a) >= ADDR_W'(DEPTH));
  endfunction

  // Address of the beat after `a`; WRAP only honoured for 2/4/8/16-beat bursts.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [7:0]        len,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;
    inc       = a + ADDR_W'(BYTES);
    mask      = ADDR_W'((int'(len) + 1) * BYTES - 1);
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = inc;
    if (burst == 2'b00)
      next_addr = a;
    else if (burst == 2'b10 && wrap_ok)
      next_addr = (a & ~mask) | (inc & mask);
  endfunction

  // Holds both address channels not-ready until the first edge after reset release.
  logic alive_reg;
  always_ff @(posedge ACLK or negedge APRESETn) begin
    if (!APRESETn) alive_reg <= 1'b0;
    else           alive_reg <= 1'b1;
  end

  // ---------------- write channel ----------------
  wstate_t           w_state_reg, w_state_next;
  logic [ADDR_W-1:0] w_addr_reg;
  logic [7:0]        w_len_reg;
  logic [7:0]        w_cnt_reg;
  logic [1:0]        w_burst_reg;
  logic              w_err_reg;
  logic [1:0]        b_resp_reg;
  logic              aw_hs, w_hs, w_beat_last, w_beat_bad, mem_we;
  logic [IDX_W-1:0]  w_idx;

  always_ff @(posedge ACLK or negedge APRESETn) begin
    if (!APRESETn) w_state_reg <= WS_IDLE;
    else           w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    AW_READY     = 1'b0;
    W_READY      = 1'b0;
    B_VALID      = 1'b0;
    case (w_state_reg)
      WS_IDLE: begin
        AW_READY = alive_reg;
        if (AW_VALID && alive_reg) w_state_next = WS_DATA;
      end
      WS_DATA: begin
        W_READY = 1'b1;
        if (W_VALID && w_beat_last) w_state_next = WS_RESP;
      end
      WS_RESP: begin
        B_VALID = 1'b1;
        if (B_READY) w_state_next = WS_IDLE;
      end
      default: w_state_next = WS_IDLE;
    endcase
  end

  assign aw_hs       = AW_VALID & AW_READY;
  assign w_hs        = W_VALID & W_READY;
  assign w_beat_last = (w_cnt_reg == w_len_reg);
  // Burst length comes from AW_LEN; W_LAST is only checked, never obeyed.
  assign w_beat_bad  = (W_LAST != w_beat_last) | beyond(w_addr_reg);
  assign mem_we      = w_hs & ~beyond(w_addr_reg);
  assign w_idx       = mem_idx(w_addr_reg);
  assign B_RESP      = b_resp_reg;

  always_ff @(posedge ACLK or negedge APRESETn) begin
    if (!APRESETn) begin
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_burst_reg <= '0;
      w_err_reg   <= 1'b0;
      b_resp_reg  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr_reg  <= AW_ADDR;
      w_len_reg   <= AW_LEN;
      w_cnt_reg   <= '0;
      w_burst_reg <= AW_BURST;
      w_err_reg   <= 1'b0;
    end else if (w_hs) begin
      w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_burst_reg);
      w_cnt_reg  <= w_cnt_reg + 8'd1;
      w_err_reg  <= w_err_reg | w_beat_bad;
      if (w_beat_last)
        b_resp_reg <= (w_err_reg | w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Memory array has no reset so contents survive APRESETn.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++)
        if (W_STRB[b]) mem[w_idx][b*8 +: 8] <= W_DATA[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_t           r_state_reg, r_state_next;
  logic [ADDR_W-1:0] r_addr_reg;
  logic [7:0]        r_len_reg;
  logic [7:0]        r_cnt_reg;
  logic [1:0]        r_burst_reg;
  logic              r_oob_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              ar_hs, r_hs, r_adv, rd_en;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge ACLK or negedge APRESETn) begin
    if (!APRESETn) r_state_reg <= RS_IDLE;
    else           r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    AR_READY     = 1'b0;
    R_VALID      = 1'b0;
    case (r_state_reg)
      RS_IDLE: begin
        AR_READY = alive_reg;
        if (AR_VALID && alive_reg) r_state_next = RS_DATA;
      end
      RS_DATA: begin
        R_VALID = 1'b1;
        if (R_READY && (r_cnt_reg == r_len_reg)) r_state_next = RS_IDLE;
      end
      default: r_state_next = RS_IDLE;
    endcase
  end

  assign ar_hs = AR_VALID & AR_READY;
  assign r_hs  = R_VALID & R_READY;
  assign r_adv = r_hs & (r_cnt_reg != r_len_reg);
  // The next beat is fetched on the accepting edge so the following cycle has no bubble.
  assign rd_addr = ar_hs ? AR_ADDR : next_addr(r_addr_reg, r_len_reg, r_burst_reg);
  assign rd_en   = ar_hs | r_adv;

  always_ff @(posedge ACLK) begin
    if (rd_en) rd_data_reg <= mem[mem_idx(rd_addr)];
  end

  always_ff @(posedge ACLK or negedge APRESETn) begin
    if (!APRESETn) begin
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_burst_reg <= '0;
      r_oob_reg   <= 1'b0;
    end else if (ar_hs) begin
      r_addr_reg  <= AR_ADDR;
      r_len_reg   <= AR_LEN;
      r_cnt_reg   <= '0;
      r_burst_reg <= AR_BURST;
      r_oob_reg   <= beyond(AR_ADDR);
    end else if (r_adv) begin
      r_addr_reg <= rd_addr;
      r_cnt_reg  <= r_cnt_reg + 8'd1;
      r_oob_reg  <= beyond(rd_addr);
    end
  end

  assign R_DATA = (R_VALID && !r_oob_reg) ? rd_data_reg : '0;
  assign R_RESP = (R_VALID && r_oob_reg) ? RESP_SLVERR : RESP_OKAY;
  assign R_LAST = R_VALID & (r_cnt_reg == r_len_reg);

endmodule

// File: tb/tb_axi_burst_mem.sv
// Bench for axi_burst_mem: directed vector table, hand-built corner sequences, then random
// bursts checked against a word-level memory model.
module tb_axi_burst_mem;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 1024;
`ifdef AXI_MEM_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk, rst_n;
  logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
  logic [DW-1:0] w_data, r_data;
  logic [3:0]    w_strb;

  axi_burst_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .ACLK(clk), .APRESETn(rst_n),
    .AW_VALID(aw_valid), .AW_READY(aw_ready), .AW_ADDR(aw_addr), .AW_LEN(aw_len), .AW_BURST(aw_burst),
    .W_VALID(w_valid), .W_READY(w_ready), .W_DATA(w_data), .W_STRB(w_strb), .W_LAST(w_last),
    .B_VALID(b_valid), .B_READY(b_ready), .B_RESP(b_resp),
    .AR_VALID(ar_valid), .AR_READY(ar_ready), .AR_ADDR(ar_addr), .AR_LEN(ar_len), .AR_BURST(ar_burst),
    .R_VALID(r_valid), .R_READY(r_ready), .R_DATA(r_data), .R_RESP(r_resp), .R_LAST(r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [DEP];

  // Word index (in the full 14-bit word space) touched by beat i of a burst.
  function automatic int unsigned beat_word(input logic [15:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    int unsigned w0, n, base;
    w0 = 32'(addr) >> 2;
    n  = 32'(len) + 1;
    if (burst == 2'b00) return w0;
    if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      base = w0 - (w0 % n);
      return base + ((w0 - base + 32'(i)) % n);
    end
    return (w0 + 32'(i)) % 16384;
  endfunction

  function automatic bit oob(input int unsigned w);
    return SLV && (w >= 32'(DEP));
  endfunction

  logic [31:0] wb_data [256];
  logic [3:0]  wb_strb [256];
  logic        wb_last [256];
  logic [31:0] rb_data [256];
  logic [1:0]  rb_resp [256];
  logic        rb_last [256];

  // ---------------- bus tasks ----------------
  task automatic send_aw(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    bit ok = 0;
    aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (aw_ready) begin ok = 1; tick(); break; end
      tick();
    end
    aw_valid = 1'b0;
    check("aw_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
    bit ok = 0;
    w_valid = 1'b0;
    repeat (gap) tick();
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (w_ready) begin ok = 1; tick(); break; end
      tick();
    end
    w_valid = 1'b0;
    check("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int bdelay, output logic [1:0] bresp, output logic [1:0] exp_bresp);
    bit ok = 0;
    bit err = 0;
    int unsigned w;
    send_aw(addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      send_w(wb_data[i], wb_strb[i], wb_last[i], int'($urandom_range(0, 1)));
      w = beat_word(addr, len, burst, i);
      if (oob(w)) err = 1;
      else for (int b = 0; b < 4; b++)
        if (wb_strb[i][b]) mm[w % DEP][b*8 +: 8] = wb_data[i][b*8 +: 8];
      if (wb_last[i] != (i == int'(len))) err = 1;
    end
    exp_bresp = err ? 2'b10 : 2'b00;
    for (int c = 0; c < 100; c++) begin
      if (b_valid) begin ok = 1; break; end
      tick();
    end
    check("b_valid_arrives", 64'(ok), 64'd1);
    bresp = b_resp;
    for (int c = 0; c < bdelay; c++) begin
      tick();
      check("b_hold_stable", {b_valid, b_resp}, {1'b1, bresp});
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("b_done_aw_ready", {b_valid, aw_ready}, 2'b01);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input int stall_beat, input int stall_len);
    bit ok = 0;
    int waited;
    logic [31:0] d0; logic [1:0] r0; logic l0;
    ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1; r_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (ar_ready) begin ok = 1; tick(); break; end
      tick();
    end
    ar_valid = 1'b0;
    check("ar_handshake", 64'(ok), 64'd1);
    check("r_first_latency", 64'(r_valid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      waited = 0;
      for (int c = 0; c < 50; c++) begin
        if (r_valid) break;
        tick();
        waited++;
      end
      check("r_beat_wait_cycles", 64'(waited), 64'd0);
      if (i == stall_beat) begin
        d0 = r_data; r0 = r_resp; l0 = r_last;
        r_ready = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
          tick();
          check("r_stall_stable", {r_valid, r_data, r_last, r_resp}, {1'b1, d0, l0, r0});
        end
      end
      r_ready = 1'b1;
      rb_data[i] = r_data; rb_resp[i] = r_resp; rb_last[i] = r_last;
      tick();
    end
    r_ready = 1'b0;
    check("r_end_ar_ready", {r_valid, ar_ready}, 2'b01);
  endtask

  task automatic check_read_model(input string tag, input logic [15:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst);
    int unsigned w;
    for (int i = 0; i <= int'(len); i++) begin
      w = beat_word(addr, len, burst, i);
      check($sformatf("%s_data%0d", tag, i), rb_data[i], oob(w) ? 32'd0 : mm[w % DEP]);
      check($sformatf("%s_resp%0d", tag, i), rb_resp[i], oob(w) ? 2'b10 : 2'b00);
      check($sformatf("%s_last%0d", tag, i), rb_last[i], i == int'(len));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0]       waddr;
    logic [7:0]        wlen;
    logic [1:0]        wburst;
    logic [31:0]       wdata;   // beat i carries wdata + i
    logic [3:0]        wstrb;
    logic [1:0]        exp_b;
    logic [15:0]       raddr;
    logic [7:0]        rlen;
    logic [1:0]        rburst;
    logic [3:0][31:0]  exp_r;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] wa, input logic [7:0] wl, input logic [1:0] wbst,
                              input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] eb,
                              input logic [15:0] ra, input logic [7:0] rl, input logic [1:0] rbst,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.waddr = wa; v.wlen = wl; v.wburst = wbst; v.wdata = wd; v.wstrb = ws; v.exp_b = eb;
    v.raddr = ra; v.rlen = rl; v.rburst = rbst;
    v.exp_r[0] = e0; v.exp_r[1] = e1; v.exp_r[2] = e2; v.exp_r[3] = e3;
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    logic [1:0]  bresp, expb;
    logic [15:0] a, ra;
    logic [7:0]  l, rl;
    logic [1:0]  bt, rbt;
    int          j;

    vecs[0] = mk(16'h0010, 8'd3, 2'b01, 32'd1,         4'hF, 2'b00, 16'h0010, 8'd3, 2'b01, 32'd1, 32'd2, 32'd3, 32'd4);
    vecs[1] = mk(16'h0000, 8'd3, 2'b01, 32'hA0,        4'hF, 2'b00, 16'h0008, 8'd3, 2'b10, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
    vecs[2] = mk(16'h0040, 8'd0, 2'b01, 32'h11223344,  4'hF, 2'b00, 16'h0040, 8'd0, 2'b01, 32'h11223344, 0, 0, 0);
    vecs[3] = mk(16'h0040, 8'd0, 2'b01, 32'hAABBCCDD,  4'h5, 2'b00, 16'h0040, 8'd0, 2'b01, 32'h11BB33DD, 0, 0, 0);
    vecs[4] = mk(16'h0080, 8'd1, 2'b00, 32'h55,        4'hF, 2'b00, 16'h0080, 8'd1, 2'b00, 32'h56, 32'h56, 0, 0);
    vecs[5] = mk(16'h001C, 8'd3, 2'b10, 32'h70,        4'hF, 2'b00, 16'h0010, 8'd3, 2'b01, 32'h71, 32'h72, 32'h73, 32'h70);
    vecs[6] = mk(16'h0200, 8'd2, 2'b10, 32'hB0,        4'hF, 2'b00, 16'h0204, 8'd1, 2'b11, 32'hB1, 32'hB2, 0, 0);

    rst_n = 1'b0;
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_burst = 0; r_ready = 0;

    // Reset state and ready timing
    repeat (3) tick();
    check("reset_outputs",
          {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last}, 64'd0);
    rst_n = 1'b1;
    check("ready_before_edge", {aw_ready, ar_ready}, 2'b00);
    tick();
    check("ready_after_edge", {aw_ready, ar_ready}, 2'b11);

    // Fill every word so the model and the RAM agree everywhere
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wb_data[i] = $urandom; wb_strb[i] = 4'hF; wb_last[i] = (i == 255);
      end
      do_write(16'(blk * 1024), 8'd255, 2'b01, 0, bresp, expb);
      check("init_bresp", bresp, expb);
    end

    // W data offered before any AW must stall
    w_valid = 1'b1; w_data = 32'hDEAD; w_strb = 4'hF; w_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("w_stall_in_idle", {w_ready, b_valid}, 2'b00);
      tick();
    end
    w_valid = 1'b0;

    // Directed table
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i <= int'(vecs[k].wlen); i++) begin
        wb_data[i] = vecs[k].wdata + 32'(i); wb_strb[i] = vecs[k].wstrb;
        wb_last[i] = (i == int'(vecs[k].wlen));
      end
      do_write(vecs[k].waddr, vecs[k].wlen, vecs[k].wburst, k % 3, bresp, expb);
      check($sformatf("vec%0d_bresp", k), bresp, vecs[k].exp_b);
      do_read(vecs[k].raddr, vecs[k].rlen, vecs[k].rburst, -1, 0);
      for (int i = 0; i <= int'(vecs[k].rlen); i++) begin
        check($sformatf("vec%0d_rdata%0d", k, i), rb_data[i], vecs[k].exp_r[i]);
        check($sformatf("vec%0d_rlast%0d", k, i), rb_last[i], i == int'(vecs[k].rlen));
        check($sformatf("vec%0d_rresp%0d", k, i), rb_resp[i], 2'b00);
      end
    end

    // R_READY low for 5 cycles mid-burst
    do_read(16'h0010, 8'd3, 2'b01, 2, 5);
    check_read_model("stall", 16'h0010, 8'd3, 2'b01);

    // W_LAST early on beat 2 of a 4-beat burst
    for (int i = 0; i < 4; i++) begin
      wb_data[i] = 32'hE0 + 32'(i); wb_strb[i] = 4'hF; wb_last[i] = (i == 1);
    end
    do_write(16'h0500, 8'd3, 2'b01, 2, bresp, expb);
    check("early_last_bresp", bresp, 2'b10);
    do_read(16'h0500, 8'd3, 2'b01, -1, 0);
    check_read_model("early_last", 16'h0500, 8'd3, 2'b01);

    // Read one word past the end
    do_read(16'h1000, 8'd0, 2'b01, -1, 0);
    check("oob_read_data", rb_data[0], SLV ? 32'd0 : mm[0]);
    check("oob_read_resp", rb_resp[0], SLV ? 2'b10 : 2'b00);

    // Same-cycle read and write of one word returns the old value
    wb_data[0] = 32'h1111_1111; wb_strb[0] = 4'hF; wb_last[0] = 1'b1;
    do_write(16'h0300, 8'd0, 2'b01, 0, bresp, expb);
    send_aw(16'h0300, 8'd0, 2'b01);
    ar_addr = 16'h0300; ar_len = 0; ar_burst = 2'b01; ar_valid = 1'b1;
    w_data = 32'h2222_2222; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
    check("rw_same_ready", {w_ready, ar_ready}, 2'b11);
    tick();
    ar_valid = 1'b0; w_valid = 1'b0;
    check("rw_same_old_data", {r_valid, r_data}, {1'b1, 32'h1111_1111});
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    mm[16'h0300 >> 2] = 32'h2222_2222;
    check("rw_same_bresp", {b_valid, b_resp}, 3'b100);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    do_read(16'h0300, 8'd0, 2'b01, -1, 0);
    check_read_model("rw_same_new", 16'h0300, 8'd0, 2'b01);

    // Reset in the middle of a write burst: no response, written beats survive
    send_aw(16'h0400, 8'd3, 2'b01);
    send_w(32'hD0, 4'hF, 1'b0, 0);
    send_w(32'hD1, 4'hF, 1'b0, 0);
    mm[256] = 32'hD0; mm[257] = 32'hD1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_mid_ready", {aw_ready, ar_ready, b_valid}, 3'b110);
    do_read(16'h0400, 8'd3, 2'b01, -1, 0);
    check_read_model("reset_keep", 16'h0400, 8'd3, 2'b01);

    // Random bursts against the model
    for (int n = 0; n < 30; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
      l  = 8'($urandom_range(0, 15));
      bt = 2'($urandom_range(0, 3));
      for (int i = 0; i <= int'(l); i++) begin
        wb_data[i] = $urandom; wb_strb[i] = 4'($urandom); wb_last[i] = (i == int'(l));
      end
      if ($urandom_range(0, 5) == 0) begin
        j = int'($urandom_range(0, 32'(l)));
        wb_last[j] = ~wb_last[j];
      end
      do_write(a, l, bt, int'($urandom_range(0, 3)), bresp, expb);
      check("rand_bresp", bresp, expb);
      if ($urandom_range(0, 1) == 0) begin
        ra = a; rl = l; rbt = bt;
      end else begin
        ra = 16'($urandom_range(0, 16'h0FFF)); rl = 8'($urandom_range(0, 15)); rbt = 2'($urandom_range(0, 3));
      end
      do_read(ra, rl, rbt, int'($urandom_range(0, 32'(rl))), int'($urandom_range(0, 3)));
      check_read_model("rand", ra, rl, rbt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
